// File: rtl/regfile_vec.sv
// ============================================================================
// Module      : regfile_vec
// Description : 16 x 256-bit vector register file, 2 async read / 1 sync write
//               ports, mapped at VBASE..VBASE+15 of the shared 5-bit address
//               space. Define REGFILE_VEC_BYPASS_EN for write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_vec #(
  parameter int                DATA_W    = 256,
  parameter int                ADDR_W    = 5,
  parameter int                NUM_VREGS = 16,
  parameter logic [ADDR_W-1:0] VBASE     = 5'h10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vwe3,
  input  logic [ADDR_W-1:0] vra1,
  input  logic [ADDR_W-1:0] vra2,
  input  logic [ADDR_W-1:0] vwa3,
  input  logic [DATA_W-1:0] vwd3,
  output logic [DATA_W-1:0] vrd1,
  output logic [DATA_W-1:0] vrd2
);

  localparam int              c_idx_w = (NUM_VREGS > 1) ? $clog2(NUM_VREGS) : 1;
  localparam logic [ADDR_W:0] c_lo    = {1'b0, VBASE};
  localparam logic [ADDR_W:0] c_hi    = c_lo + (ADDR_W+1)'(NUM_VREGS);

  // Widened by one bit so VBASE+NUM_VREGS can reach past the top address.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= c_lo) && ({1'b0, a} < c_hi);
  endfunction

  function automatic logic [c_idx_w-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return c_idx_w'(a - VBASE);
  endfunction

  logic [DATA_W-1:0]  r_vrf [NUM_VREGS];
  logic               w_we_hit;
  logic [c_idx_w-1:0] w_wa_idx;
  logic [c_idx_w-1:0] w_ra1_idx;
  logic [c_idx_w-1:0] w_ra2_idx;
  logic               w_ra1_ok;
  logic               w_ra2_ok;
  logic [NUM_VREGS-1:0] w_wsel;
  logic [DATA_W-1:0]  w_rd1_store;
  logic [DATA_W-1:0]  w_rd2_store;

  assign w_wa_idx  = to_idx(vwa3);
  assign w_ra1_idx = to_idx(vra1);
  assign w_ra2_idx = to_idx(vra2);
  assign w_ra1_ok  = in_range(vra1);
  assign w_ra2_ok  = in_range(vra2);
  assign w_we_hit  = vwe3 & ~rst & in_range(vwa3);

  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < NUM_VREGS; i++) begin
      w_wsel[i] = w_we_hit && (w_wa_idx == c_idx_w'(i));
    end
  end

  generate
    for (genvar g = 0; g < NUM_VREGS; g++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vrf[g] <= '0;
        end else if (w_wsel[g]) begin
          r_vrf[g] <= vwd3;
        end
      end
    end
  endgenerate

  always_comb begin
    w_rd1_store = '0;
    w_rd2_store = '0;
    if (w_ra1_ok) w_rd1_store = r_vrf[w_ra1_idx];
    if (w_ra2_ok) w_rd2_store = r_vrf[w_ra2_idx];
  end

`ifdef REGFILE_VEC_BYPASS_EN
  // Forward the in-flight write so a same-cycle reader sees the new value.
  assign vrd1 = (w_we_hit && (vra1 == vwa3)) ? vwd3 : w_rd1_store;
  assign vrd2 = (w_we_hit && (vra2 == vwa3)) ? vwd3 : w_rd2_store;
`else
  assign vrd1 = w_rd1_store;
  assign vrd2 = w_rd2_store;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_vec.sv
// Self-checking bench for regfile_vec against an array-based reference model.
`default_nettype none

module tb_regfile_vec;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vwe3 = 1'b0;
  logic [4:0]   vra1 = '0;
  logic [4:0]   vra2 = '0;
  logic [4:0]   vwa3 = '0;
  logic [255:0] vwd3 = '0;
  logic [255:0] vrd1;
  logic [255:0] vrd2;

  int vectors = 0;
  int miscompares = 0;

  logic [255:0] model [16];

  regfile_vec dut (
    .clk  (clk),
    .rst  (rst),
    .vwe3 (vwe3),
    .vra1 (vra1),
    .vra2 (vra2),
    .vwa3 (vwa3),
    .vwd3 (vwd3),
    .vrd1 (vrd1),
    .vrd2 (vrd2)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] exp_rd(input logic [4:0] ra);
    logic [255:0] v;
    v = '0;
    if (!rst && ra >= 5'h10) v = model[ra - 5'h10];
`ifdef REGFILE_VEC_BYPASS_EN
    if (vwe3 && !rst && vwa3 >= 5'h10 && ra == vwa3) v = vwd3;
`endif
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  // Applied right after the rising edge, using inputs still held from before it.
  task automatic model_commit();
    if (vwe3 && !rst && vwa3 >= 5'h10) model[vwa3 - 5'h10] = vwd3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    for (int a = 16; a < 32; a++) begin
      vra1 = 5'(a);
      vra2 = 5'(47 - a);
      #1;
      vectors++;
      if (vrd1 !== 256'd0 || vrd2 !== 256'd0) begin
        miscompares++;
        $display("FAIL reset_read addr=%h vrd1=%h vrd2=%h want 0", vra1, vrd1, vrd2);
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    vwe3 = 1'b1; vwa3 = 5'h10; vwd3 = {32{8'hAA}}; vra1 = 5'h10; vra2 = 5'h11;
    #1;
    vectors++;
    if (vrd1 !== exp_rd(vra1)) begin
      miscompares++;
      $display("FAIL wr_pre_edge vrd1=%h want %h", vrd1, exp_rd(vra1));
    end
    @(posedge clk); model_commit(); #1;
    vectors++;
    if (vrd1 !== {32{8'hAA}} || vrd2 !== 256'd0) begin
      miscompares++;
      $display("FAIL wr_post_edge vrd1=%h vrd2=%h want AA.. / 0", vrd1, vrd2);
    end
    @(negedge clk); vwe3 = 1'b0;
  endtask

  task automatic test_write_disabled();
    @(negedge clk);
    vwe3 = 1'b0; vwa3 = 5'h12; vwd3 = {32{8'h55}}; vra1 = 5'h12; vra2 = 5'h12;
    @(posedge clk); model_commit(); #1;
    vectors++;
    if (vrd1 !== 256'd0 || vrd2 !== 256'd0) begin
      miscompares++;
      $display("FAIL we_off vrd1=%h vrd2=%h want 0", vrd1, vrd2);
    end
  endtask

  task automatic test_scalar_space();
    @(negedge clk);
    vwe3 = 1'b1; vwa3 = 5'h05; vwd3 = '1; vra1 = 5'h05; vra2 = 5'h15;
    @(posedge clk); model_commit(); #1;
    vectors++;
    if (vrd1 !== 256'd0 || vrd2 !== 256'd0) begin
      miscompares++;
      $display("FAIL scalar_addr vrd1=%h vrd2=%h want 0", vrd1, vrd2);
    end
    @(negedge clk); vwe3 = 1'b0;
    for (int a = 16; a < 32; a++) begin
      vra1 = 5'(a);
      #1;
      vectors++;
      if (vrd1 !== exp_rd(vra1)) begin
        miscompares++;
        $display("FAIL scalar_no_side_effect addr=%h got %h want %h", vra1, vrd1, exp_rd(vra1));
      end
    end
  endtask

  task automatic test_full_range();
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      vwe3 = 1'b1; vwa3 = 5'(16 + n); vwd3 = {32{8'(n)}};
      @(posedge clk); model_commit();
    end
    @(negedge clk); vwe3 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      vra1 = 5'(16 + n);
      vra2 = 5'(31 - n);
      #1;
      vectors++;
      if (vrd1 !== {32{8'(n)}} || vrd2 !== {32{8'(15 - n)}}) begin
        miscompares++;
        $display("FAIL full_range n=%0d vrd1=%h vrd2=%h", n, vrd1, vrd2);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    vra1 = 5'h1F; vra2 = 5'h14;
    #2; rst = 1'b1; model_clear();
    #1;
    vectors++;
    if (vrd1 !== 256'd0 || vrd2 !== 256'd0) begin
      miscompares++;
      $display("FAIL async_reset vrd1=%h vrd2=%h want 0", vrd1, vrd2);
    end
    vwe3 = 1'b1; vwa3 = 5'h14; vwd3 = '1;
    @(posedge clk); #1;
    vectors++;
    if (vrd2 !== 256'd0) begin
      miscompares++;
      $display("FAIL reset_blocks_write vrd2=%h want 0", vrd2);
    end
    @(negedge clk); rst = 1'b0; vwe3 = 1'b0;
    #1;
    vectors++;
    if (vrd1 !== 256'd0 || vrd2 !== 256'd0) begin
      miscompares++;
      $display("FAIL post_reset vrd1=%h vrd2=%h want 0", vrd1, vrd2);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    vwe3 = 1'b1; vwa3 = 5'h13; vwd3 = {32{8'hC3}}; vra1 = 5'h13; vra2 = 5'h13;
    #1;
    vectors++;
`ifdef REGFILE_VEC_BYPASS_EN
    if (vrd1 !== {32{8'hC3}} || vrd2 !== {32{8'hC3}}) begin
`else
    if (vrd1 !== 256'd0 || vrd2 !== 256'd0) begin
`endif
      miscompares++;
      $display("FAIL same_cycle_rw vrd1=%h vrd2=%h", vrd1, vrd2);
    end
    @(posedge clk); model_commit(); #1;
    vectors++;
    if (vrd1 !== {32{8'hC3}}) begin
      miscompares++;
      $display("FAIL rw_after_edge vrd1=%h want C3..", vrd1);
    end
    @(negedge clk); vwe3 = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      vwe3 = 1'($urandom);
      vwa3 = 5'($urandom);
      vwd3 = rand256();
      vra1 = ($urandom_range(0, 3) == 0) ? vwa3 : 5'($urandom);
      vra2 = ($urandom_range(0, 3) == 0) ? vwa3 : 5'($urandom);
      #1;
      vectors++;
      if (vrd1 !== exp_rd(vra1) || vrd2 !== exp_rd(vra2)) begin
        miscompares++;
        $display("FAIL rand_pre k=%0d ra1=%h ra2=%h vrd1=%h vrd2=%h", k, vra1, vra2, vrd1, vrd2);
      end
      @(posedge clk); model_commit(); #1;
      vectors++;
      if (vrd1 !== exp_rd(vra1) || vrd2 !== exp_rd(vra2)) begin
        miscompares++;
        $display("FAIL rand_post k=%0d ra1=%h ra2=%h vrd1=%h vrd2=%h", k, vra1, vra2, vrd1, vrd2);
      end
    end
    @(negedge clk); vwe3 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [255:0] d0, d1;
    d0 = rand256();
    d1 = rand256();
    @(negedge clk); vwe3 = 1'b1; vwa3 = 5'h1A; vwd3 = d0; vra1 = 5'h1A; vra2 = 5'h1B;
    @(posedge clk); model_commit();
    @(negedge clk); vwa3 = 5'h1B; vwd3 = d1;
    #1;
    vectors++;
    if (vrd1 !== d0) begin
      miscompares++;
      $display("FAIL b2b_first vrd1=%h want %h", vrd1, d0);
    end
    @(posedge clk); model_commit();
    @(negedge clk); vwe3 = 1'b0;
    #1;
    vectors++;
    if (vrd1 !== d0 || vrd2 !== d1) begin
      miscompares++;
      $display("FAIL b2b_both vrd1=%h vrd2=%h want %h / %h", vrd1, vrd2, d0, d1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_disabled();
    test_scalar_space();
    test_full_range();
    test_async_reset();
    test_bypass();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
